// File: rtl/issue_hazard_ctrl_pkg.sv
// issue_hazard_ctrl_pkg: shared class encoding, latencies and scoreboard width (ISSUE_DUAL_EN selects dual issue)
package issue_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        CLS_ALU  = 2'd0,
        CLS_LOAD = 2'd1,
        CLS_MUL  = 2'd2,
        CLS_DIV  = 2'd3
    } cls_t;

    localparam int LAT_ALU = 1;
    localparam int LAT_MEM = 2;
    localparam int PEND_W  = 4;

    function automatic logic [PEND_W-1:0] lat_val(input cls_t c, input int div_lat);
        return c == CLS_ALU ? PEND_W'(LAT_ALU - 1) :
               c == CLS_DIV ? PEND_W'(div_lat - 1) : PEND_W'(LAT_MEM - 1);
    endfunction

endpackage

// File: rtl/issue_hazard_ctrl_if.sv
// issue_hazard_ctrl_if: rf-stage slot bundle, pipeline control and issue results
interface issue_hazard_ctrl_if;
    import issue_hazard_ctrl_pkg::*;

    logic       vld0, vld1;
    logic [4:0] rj0, rk0, rd0, rj1, rk1, rd1;
    logic       we0, we1;
    cls_t       cls0, cls1;
    logic       exe_stall, flush;
    logic       issue0, issue1, div_cancel, div_busy;

    modport master (
        output vld0, vld1, rj0, rk0, rd0, rj1, rk1, rd1, we0, we1, cls0, cls1, exe_stall, flush,
        input  issue0, issue1, div_cancel, div_busy
    );

    modport slave (
        input  vld0, vld1, rj0, rk0, rd0, rj1, rk1, rd1, we0, we1, cls0, cls1, exe_stall, flush,
        output issue0, issue1, div_cancel, div_busy
    );

endinterface

// File: rtl/issue_hazard_ctrl_reg_pend_table.sv
// reg_pend_table: per-register pending-latency counters; load port 1 exists only under ISSUE_DUAL_EN
module reg_pend_table
    import issue_hazard_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              dec_en,
    input  logic              ld0_en,
    input  logic [4:0]        ld0_rd,
    input  logic [PEND_W-1:0] ld0_val,
`ifdef ISSUE_DUAL_EN
    input  logic              ld1_en,
    input  logic [4:0]        ld1_rd,
    input  logic [PEND_W-1:0] ld1_val,
    input  logic [4:0]        rj1,
    input  logic [4:0]        rk1,
    input  logic [4:0]        rd1,
    output logic              bj1,
    output logic              bk1,
    output logic              bd1,
`endif
    input  logic [4:0]        rj0,
    input  logic [4:0]        rk0,
    input  logic [4:0]        rd0,
    output logic              bj0,
    output logic              bk0,
    output logic              bd0
);

    // Entry 0 is never loaded (loaders gate rd=0), so it stays zero and r0 reads as ready
    logic [PEND_W-1:0] pend [32];

    // Load wins over decrement; decrement freezes while the pipeline is stalled
    always_ff @(posedge clk) begin
        for (int i = 0; i < 32; i++) begin
            if (rst || clr)
                pend[i] <= '0;
`ifdef ISSUE_DUAL_EN
            else if (ld1_en && ld1_rd == 5'(i))
                pend[i] <= ld1_val;
`endif
            else if (ld0_en && ld0_rd == 5'(i))
                pend[i] <= ld0_val;
            else if (dec_en && pend[i] != '0)
                pend[i] <= pend[i] - 1'b1;
        end
    end

    // Busy bits for each slot's operands and destination
    always_comb begin
        bj0 = pend[rj0] != '0;
        bk0 = pend[rk0] != '0;
        bd0 = pend[rd0] != '0;
`ifdef ISSUE_DUAL_EN
        bj1 = pend[rj1] != '0;
        bk1 = pend[rk1] != '0;
        bd1 = pend[rd1] != '0;
`endif
    end

endmodule

// File: rtl/issue_hazard_ctrl.sv
// issue_hazard_ctrl: rf-stage issue gating, pending scoreboard and divider occupancy (ISSUE_DUAL_EN enables slot 1)
module issue_hazard_ctrl
    import issue_hazard_ctrl_pkg::*;
#(
    parameter int DIV_LAT = 8
) (
    input  logic                clk,
    input  logic                rst,
    issue_hazard_ctrl_if.slave  bus
);

    logic [PEND_W-1:0] div_cnt;
    logic              busy, iss0, div0, blk0, bj0, bk0, bd0, div_iss;

`ifdef ISSUE_DUAL_EN
    logic iss1, div1, blk1, pair, bj1, bk1, bd1;
`else
    logic unused_slot1;
    assign unused_slot1 = ^{bus.vld1, bus.rj1, bus.rk1, bus.rd1, bus.we1, bus.cls1};
`endif

    reg_pend_table u_pend (
        .clk     (clk),
        .rst     (rst),
        .clr     (bus.flush),
        .dec_en  (!bus.exe_stall),
        .ld0_en  (iss0 && bus.we0 && bus.rd0 != 5'd0),
        .ld0_rd  (bus.rd0),
        .ld0_val (lat_val(bus.cls0, DIV_LAT)),
`ifdef ISSUE_DUAL_EN
        .ld1_en  (iss1 && bus.we1 && bus.rd1 != 5'd0),
        .ld1_rd  (bus.rd1),
        .ld1_val (lat_val(bus.cls1, DIV_LAT)),
        .rj1     (bus.rj1),
        .rk1     (bus.rk1),
        .rd1     (bus.rd1),
        .bj1     (bj1),
        .bk1     (bk1),
        .bd1     (bd1),
`endif
        .rj0     (bus.rj0),
        .rk0     (bus.rk0),
        .rd0     (bus.rd0),
        .bj0     (bj0),
        .bk0     (bk0),
        .bd0     (bd0)
    );

    // Source, WAW and divider checks; slot 1 additionally needs slot 0 to go and no intra-pair conflict
    always_comb begin
        busy  = div_cnt != '0;
        div0  = bus.cls0 == CLS_DIV;
        blk0  = bj0 || bk0 || (bus.we0 && bd0) || (div0 && busy);
        iss0  = bus.vld0 && !bus.exe_stall && !bus.flush && !blk0;
`ifdef ISSUE_DUAL_EN
        div1  = bus.cls1 == CLS_DIV;
        blk1  = bj1 || bk1 || (bus.we1 && bd1) || (div1 && busy);
        pair  = (bus.we0 && bus.rd0 != 5'd0 &&
                 (bus.rd0 == bus.rj1 || bus.rd0 == bus.rk1 || bus.rd0 == bus.rd1)) || (div0 && div1);
        iss1  = iss0 && bus.vld1 && !blk1 && !pair;
        div_iss = (iss0 && div0) || (iss1 && div1);
        bus.issue1 = iss1;
`else
        div_iss = iss0 && div0;
        bus.issue1 = 1'b0;
`endif
        bus.issue0     = iss0;
        bus.div_busy   = busy;
        bus.div_cancel = bus.flush && busy;
    end

    // Divider occupancy counter follows the same hold/decrement rule as the scoreboard
    always_ff @(posedge clk) begin
        if (rst || bus.flush)
            div_cnt <= '0;
        else if (div_iss)
            div_cnt <= PEND_W'(DIV_LAT - 1);
        else if (!bus.exe_stall && div_cnt != '0)
            div_cnt <= div_cnt - 1'b1;
    end

endmodule

// File: tb/tb_issue_hazard_ctrl.sv
// tb_issue_hazard_ctrl: directed vectors for the issue hazard controller (DIV_LAT=8)
module tb_issue_hazard_ctrl;
    import issue_hazard_ctrl_pkg::*;

`ifdef ISSUE_DUAL_EN
    localparam logic DUAL = 1'b1;
`else
    localparam logic DUAL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    issue_hazard_ctrl_if bus ();

    issue_hazard_ctrl #(.DIV_LAT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic s0(input logic v, input logic [4:0] j, input logic [4:0] k,
                      input logic [4:0] d, input logic w, input cls_t c);
        bus.vld0 = v; bus.rj0 = j; bus.rk0 = k; bus.rd0 = d; bus.we0 = w; bus.cls0 = c;
    endtask

    task automatic s1(input logic v, input logic [4:0] j, input logic [4:0] k,
                      input logic [4:0] d, input logic w, input cls_t c);
        bus.vld1 = v; bus.rj1 = j; bus.rk1 = k; bus.rd1 = d; bus.we1 = w; bus.cls1 = c;
    endtask

    initial begin
        rst = 1'b1;
        bus.exe_stall = 1'b0;
        bus.flush = 1'b0;
        s0(0, 0, 0, 0, 0, CLS_ALU);
        s1(0, 0, 0, 0, 0, CLS_ALU);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_busy", bus.div_busy, 1'b0);
        chk("rst_cancel", bus.div_cancel, 1'b0);
        chk("rst_iss0", bus.issue0, 1'b0);
        chk("rst_iss1", bus.issue1, 1'b0);

        s0(1, 1, 2, 5, 1, CLS_ALU); #1 chk("alu_prod", bus.issue0, 1'b1); cyc();
        s0(1, 5, 0, 6, 1, CLS_ALU); #1 chk("alu_cons", bus.issue0, 1'b1); cyc();

        s0(1, 0, 0, 7, 1, CLS_LOAD); #1 chk("ld_prod", bus.issue0, 1'b1); cyc();
        s0(1, 0, 7, 8, 1, CLS_ALU);  #1 chk("ld_use_t1", bus.issue0, 1'b0); cyc();
        #1 chk("ld_use_t2", bus.issue0, 1'b1); cyc();

        s0(1, 0, 0, 10, 1, CLS_MUL); cyc();
        s0(1, 0, 0, 10, 1, CLS_ALU); #1 chk("waw_block", bus.issue0, 1'b0); cyc();
        #1 chk("waw_go", bus.issue0, 1'b1); cyc();

        s0(1, 0, 0, 0, 1, CLS_LOAD); cyc();
        s0(1, 0, 0, 21, 1, CLS_ALU); #1 chk("r0_ready", bus.issue0, 1'b1); cyc();

        s0(1, 1, 1, 3, 1, CLS_ALU); s1(1, 3, 0, 6, 1, CLS_ALU);
        #1 chk("pair_iss0", bus.issue0, 1'b1); chk("pair_iss1", bus.issue1, 1'b0); cyc();
        s1(0, 0, 0, 0, 0, CLS_ALU);
        s0(1, 3, 0, 6, 1, CLS_ALU); #1 chk("pair_next", bus.issue0, 1'b1); cyc();

        s0(1, 1, 0, 11, 1, CLS_ALU); s1(1, 12, 0, 13, 1, CLS_LOAD);
        #1 chk("dual_iss0", bus.issue0, 1'b1); chk("dual_iss1", bus.issue1, DUAL); cyc();
        s1(0, 0, 0, 0, 0, CLS_ALU);
        s0(1, 13, 0, 0, 0, CLS_ALU); #1 chk("s1_wr_use", bus.issue0, !DUAL); cyc();
        #1 chk("s1_wr_go", bus.issue0, 1'b1); cyc();

        s0(1, 0, 0, 14, 1, CLS_LOAD); cyc();
        s0(1, 1, 0, 0, 0, CLS_ALU); s1(1, 14, 0, 0, 0, CLS_ALU);
        #1 chk("s1_src_iss0", bus.issue0, 1'b1); chk("s1_src_iss1", bus.issue1, 1'b0); cyc();

        s0(1, 0, 0, 9, 1, CLS_DIV); s1(1, 0, 0, 17, 1, CLS_DIV);
        #1 chk("div_iss0", bus.issue0, 1'b1); chk("div_pair", bus.issue1, 1'b0);
        chk("div_t0_busy", bus.div_busy, 1'b0); cyc();
        s1(0, 0, 0, 0, 0, CLS_ALU);
        for (int k = 1; k <= 6; k++) begin
            s0(1, 9, 0, 0, 0, CLS_ALU);
            #1 chk($sformatf("div_rd_t%0d", k), bus.issue0, 1'b0);
            chk($sformatf("div_busy_t%0d", k), bus.div_busy, 1'b1); cyc();
        end
        s0(1, 0, 0, 15, 1, CLS_DIV);
        #1 chk("div2_t7", bus.issue0, 1'b0); chk("div_busy_t7", bus.div_busy, 1'b1); cyc();
        s1(1, 9, 0, 0, 0, CLS_ALU);
        #1 chk("div2_t8", bus.issue0, 1'b1); chk("div_rd_t8", bus.issue1, DUAL);
        chk("div_busy_t8", bus.div_busy, 1'b0); cyc();
        s1(0, 0, 0, 0, 0, CLS_ALU);
        s0(0, 0, 0, 0, 0, CLS_ALU);
        #1 chk("fl_busy_t1", bus.div_busy, 1'b1); chk("fl_nocancel", bus.div_cancel, 1'b0); cyc();
        cyc();
        bus.flush = 1'b1; s0(1, 0, 0, 20, 1, CLS_LOAD);
        #1 chk("fl_cancel", bus.div_cancel, 1'b1); chk("fl_noiss", bus.issue0, 1'b0); cyc();
        bus.flush = 1'b0; s0(1, 15, 20, 0, 0, CLS_ALU);
        #1 chk("fl_rd_iss", bus.issue0, 1'b1); chk("fl_busy_t4", bus.div_busy, 1'b0);
        chk("fl_cancel_t4", bus.div_cancel, 1'b0); cyc();

        s0(1, 0, 0, 4, 1, CLS_LOAD); #1 chk("st_prod", bus.issue0, 1'b1); cyc();
        bus.exe_stall = 1'b1; s0(1, 4, 0, 0, 0, CLS_ALU);
        #1 chk("st_t1", bus.issue0, 1'b0); cyc();
        #1 chk("st_t2", bus.issue0, 1'b0); cyc();
        bus.exe_stall = 1'b0;
        #1 chk("st_t3", bus.issue0, 1'b0); cyc();
        #1 chk("st_t4", bus.issue0, 1'b1); cyc();

        s0(1, 0, 0, 8, 1, CLS_DIV); cyc();
        s0(0, 0, 0, 0, 0, CLS_ALU); #1 chk("rdiv_busy", bus.div_busy, 1'b1);
        rst = 1'b1; cyc();
        rst = 1'b0; s0(1, 8, 0, 0, 0, CLS_ALU);
        #1 chk("rdiv_clr", bus.div_busy, 1'b0); chk("rdiv_rd", bus.issue0, 1'b1); cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
